// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: builds a DIGITS-wide BCD setting, offers it to the countdown core over valid/ready, then issues start.
// Optional macro TIME_CHECK_EN rejects a confirm when the entry is zero or the seconds-tens digit exceeds 5.
module keypad_entry_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  keydown_num,
  input  logic [3:0]            num,
  input  logic                  keydown_confirm,
  input  logic                  keydown_clear,
  input  logic                  keydown_start,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic                  editing,
  output logic                  load_valid,
  output logic [4*DIGITS-1:0]   load_bcd,
  input  logic                  load_ready,
  output logic                  start_pulse,
  output logic                  key_err
);

  localparam int unsigned W = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EDIT  = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_ARMED = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] entry_q, entry_d;
  logic [W-1:0] lbcd_q, lbcd_d;
  logic         lv_q, lv_d;
  logic         start_q, start_d;
  logic         err_q, err_d;
  logic         editing_q;

  logic         num_sel;
  logic         num_ok;
  logic         confirm_ok;
  logic [W-1:0] num_zext;

  // A digit is only acted on when no higher-priority key arrives in the same cycle.
  assign num_sel  = keydown_num & ~keydown_clear & ~keydown_confirm & ~keydown_start;
  assign num_ok   = (num <= 4'd9);
  assign num_zext = {{(W-4){1'b0}}, num};

`ifdef TIME_CHECK_EN
  assign confirm_ok = (entry_q != '0) && (entry_q[7:4] <= 4'd5);
`else
  assign confirm_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    lbcd_d  = lbcd_q;
    lv_d    = lv_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (num_sel) begin
          if (num_ok) begin
            entry_d = num_zext;
            state_d = S_EDIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EDIT: begin
        if (keydown_clear) begin
          entry_d = '0;
          state_d = S_IDLE;
        end else if (keydown_confirm) begin
          if (confirm_ok) begin
            lbcd_d  = entry_q;
            lv_d    = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end else if (num_sel) begin
          if (num_ok) entry_d = {entry_q[W-5:0], num};
          else        err_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (load_ready) begin
          lv_d    = 1'b0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (keydown_clear) begin
          entry_d = '0;
          state_d = S_IDLE;
        end else if (!keydown_confirm && keydown_start) begin
          start_d = 1'b1;
          state_d = S_IDLE;
        end else if (num_sel) begin
          if (num_ok) begin
            entry_d = num_zext;
            state_d = S_EDIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        lv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      entry_q   <= '0;
      lbcd_q    <= '0;
      lv_q      <= 1'b0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      lbcd_q    <= lbcd_d;
      lv_q      <= lv_d;
      start_q   <= start_d;
      err_q     <= err_d;
      editing_q <= (state_d == S_EDIT);
    end
  end

  assign entry_bcd   = entry_q;
  assign editing     = editing_q;
  assign load_valid  = lv_q;
  assign load_bcd    = lbcd_q;
  assign start_pulse = start_q;
  assign key_err     = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed vector table, hand sequences, and randomized run against a behavioural model.
module tb_keypad_entry_ctrl;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          keydown_num = 1'b0;
  logic [3:0]    num = '0;
  logic          keydown_confirm = 1'b0;
  logic          keydown_clear = 1'b0;
  logic          keydown_start = 1'b0;
  logic          load_ready = 1'b0;
  logic [W-1:0]  entry_bcd;
  logic          editing;
  logic          load_valid;
  logic [W-1:0]  load_bcd;
  logic          start_pulse;
  logic          key_err;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  keypad_entry_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .keydown_num(keydown_num), .num(num),
    .keydown_confirm(keydown_confirm), .keydown_clear(keydown_clear),
    .keydown_start(keydown_start),
    .entry_bcd(entry_bcd), .editing(editing),
    .load_valid(load_valid), .load_bcd(load_bcd), .load_ready(load_ready),
    .start_pulse(start_pulse), .key_err(key_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr, conf, st, kn;
    logic [3:0] n;
    logic rdy;
    logic [15:0] e_entry;
    logic e_edit, e_lv;
    logic [15:0] e_lbcd;
    logic e_start, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_entry, input logic e_edit,
                         input logic e_lv, input logic [15:0] e_lbcd,
                         input logic e_start, input logic e_err);
    chk({tag, ".entry_bcd"},   entry_bcd,   e_entry);
    chk({tag, ".editing"},     {15'd0, editing},     {15'd0, e_edit});
    chk({tag, ".load_valid"},  {15'd0, load_valid},  {15'd0, e_lv});
    chk({tag, ".load_bcd"},    load_bcd,    e_lbcd);
    chk({tag, ".start_pulse"}, {15'd0, start_pulse}, {15'd0, e_start});
    chk({tag, ".key_err"},     {15'd0, key_err},     {15'd0, e_err});
  endtask

  task automatic drive(input logic clr, input logic conf, input logic st, input logic kn,
                       input logic [3:0] n, input logic rdy);
    @(negedge clk);
    keydown_clear = clr; keydown_confirm = conf; keydown_start = st;
    keydown_num = kn; num = n; load_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    keydown_clear = 0; keydown_confirm = 0; keydown_start = 0;
    keydown_num = 0; num = 0; load_ready = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 0;
    keydown_clear = 0; keydown_confirm = 0; keydown_start = 0;
    keydown_num = 0; num = 0; load_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all(tag, 16'h0, 0, 0, 16'h0, 0, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  function automatic vec_t mk(input logic clr, conf, st, kn, input logic [3:0] n, input logic rdy,
                              input logic [15:0] e_entry, input logic e_edit, e_lv,
                              input logic [15:0] e_lbcd, input logic e_start, e_err);
    vec_t v;
    v.clr = clr; v.conf = conf; v.st = st; v.kn = kn; v.n = n; v.rdy = rdy;
    v.e_entry = e_entry; v.e_edit = e_edit; v.e_lv = e_lv; v.e_lbcd = e_lbcd;
    v.e_start = e_start; v.e_err = e_err;
    return v;
  endfunction

  // Behavioural reference: modes 0 idle, 1 editing, 2 awaiting transfer, 3 armed.
  int unsigned m_mode, m_entry, m_lbcd;
  bit m_lv, m_start, m_err;

  function automatic bit time_ok(input int unsigned e);
`ifdef TIME_CHECK_EN
    return (e != 0) && (((e / 16) % 16) <= 5);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_entry = 0; m_lbcd = 0; m_lv = 0; m_start = 0; m_err = 0;
  endtask

  task automatic model_step(input bit clr, conf, st, kn, input int unsigned n, input bit rdy);
    m_start = 0; m_err = 0;
    if (m_mode == 2) begin
      if (rdy) begin m_lv = 0; m_mode = 3; end
    end else if (clr) begin
      if (m_mode != 0) begin m_entry = 0; m_mode = 0; end
    end else if (conf) begin
      if (m_mode == 1) begin
        if (time_ok(m_entry)) begin m_lbcd = m_entry; m_lv = 1; m_mode = 2; end
        else m_err = 1;
      end
    end else if (st) begin
      if (m_mode == 3) begin m_start = 1; m_mode = 0; end
    end else if (kn) begin
      if (n > 9) m_err = 1;
      else if (m_mode == 1) m_entry = (m_entry * 16 + n) % (1 << W);
      else begin m_entry = n; m_mode = 1; end
    end
  endtask

  initial begin
    // clr conf st kn n rdy | entry edit lv lbcd start err
    vecs.push_back(mk(0,0,0,1,4'd1,0, 16'h0001,1,0,16'h0000,0,0));
    vecs.push_back(mk(0,0,0,1,4'd2,0, 16'h0012,1,0,16'h0000,0,0));
    vecs.push_back(mk(0,0,0,1,4'hA,0, 16'h0012,1,0,16'h0000,0,1));
    vecs.push_back(mk(0,0,0,1,4'd3,0, 16'h0123,1,0,16'h0000,0,0));
    vecs.push_back(mk(0,0,0,1,4'd0,0, 16'h1230,1,0,16'h0000,0,0));
    vecs.push_back(mk(0,1,0,0,4'd0,0, 16'h1230,0,1,16'h1230,0,0));
    vecs.push_back(mk(1,0,0,0,4'd0,0, 16'h1230,0,1,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd5,0, 16'h1230,0,1,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'hB,0, 16'h1230,0,1,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,0,4'd0,1, 16'h1230,0,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,1,1,4'd7,0, 16'h1230,0,0,16'h1230,1,0));
    vecs.push_back(mk(0,0,0,0,4'd0,0, 16'h1230,0,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd1,0, 16'h0001,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd2,0, 16'h0012,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd3,0, 16'h0123,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd4,0, 16'h1234,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd5,0, 16'h2345,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,1,0,4'd0,0, 16'h2345,1,0,16'h1230,0,0));
    vecs.push_back(mk(1,0,0,0,4'd0,0, 16'h0000,0,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd9,0, 16'h0009,1,0,16'h1230,0,0));
    vecs.push_back(mk(1,1,0,0,4'd0,1, 16'h0000,0,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd1,0, 16'h0001,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd2,0, 16'h0012,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd7,0, 16'h0127,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd0,0, 16'h1270,1,0,16'h1230,0,0));
`ifdef TIME_CHECK_EN
    vecs.push_back(mk(0,1,0,0,4'd0,1, 16'h1270,1,0,16'h1230,0,1));
    vecs.push_back(mk(0,0,0,0,4'd0,1, 16'h1270,1,0,16'h1230,0,0));
    vecs.push_back(mk(1,0,0,0,4'd0,0, 16'h0000,0,0,16'h1230,0,0));
    vecs.push_back(mk(0,0,0,1,4'd0,0, 16'h0000,1,0,16'h1230,0,0));
    vecs.push_back(mk(0,1,0,0,4'd0,1, 16'h0000,1,0,16'h1230,0,1));
`else
    vecs.push_back(mk(0,1,0,0,4'd0,1, 16'h1270,0,1,16'h1270,0,0));
    vecs.push_back(mk(0,0,0,0,4'd0,1, 16'h1270,0,0,16'h1270,0,0));
    vecs.push_back(mk(0,0,0,1,4'd0,0, 16'h0000,1,0,16'h1270,0,0));
    vecs.push_back(mk(0,1,0,0,4'd0,1, 16'h0000,0,1,16'h0000,0,0));
`endif

    do_reset("reset0");
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].conf, vecs[i].st, vecs[i].kn, vecs[i].n, vecs[i].rdy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_entry, vecs[i].e_edit, vecs[i].e_lv,
              vecs[i].e_lbcd, vecs[i].e_start, vecs[i].e_err);
    end

    // Ten-cycle stall with key noise while the load is pending.
    do_reset("reset1");
    drive(0,0,0,1,4'd4,0);
    drive(0,0,0,1,4'd5,0);
    drive(0,1,0,0,4'd0,0);
    for (int i = 0; i < 10; i++) begin
      drive(i % 3 == 0, 0, i % 4 == 1, 1, 4'(i), 0);
      chk_all($sformatf("stall%0d", i), 16'h0045, 0, 1, 16'h0045, 0, 0);
    end
    drive(0,0,0,0,4'd0,1);
    chk_all("stall_xfer", 16'h0045, 0, 0, 16'h0045, 0, 0);
    drive(0,0,1,0,4'd0,0);
    chk_all("stall_start", 16'h0045, 0, 0, 16'h0045, 1, 0);
    drive(0,0,0,0,4'd0,0);
    chk_all("start_once", 16'h0045, 0, 0, 16'h0045, 0, 0);

    // Invalid digit in idle, then the error pulse must clear.
    drive(0,0,0,1,4'hF,0);
    chk_all("idle_bad", 16'h0045, 0, 0, 16'h0045, 0, 1);
    drive(0,0,0,0,4'd0,0);
    chk_all("idle_bad_clr", 16'h0045, 0, 0, 16'h0045, 0, 0);

    // Asynchronous reset while the load is pending.
    drive(0,0,0,1,4'd8,0);
    drive(0,0,0,1,4'd1,0);
    drive(0,1,0,0,4'd0,0);
    chk_all("pre_async", 16'h0081, 0, 1, 16'h0081, 0, 0);
    @(negedge clk);
    keydown_confirm = 0; keydown_num = 0;
    rst_n = 0;
    #1;
    chk_all("async_rst", 16'h0, 0, 0, 16'h0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    // Randomized run against the model.
    do_reset("reset2");
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit clr, conf, st, kn, rdy;
      int unsigned n;
      clr  = ($urandom_range(0, 15) == 0);
      conf = ($urandom_range(0, 5) == 0);
      st   = ($urandom_range(0, 5) == 0);
      kn   = ($urandom_range(0, 1) == 0);
      n    = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      rdy  = ($urandom_range(0, 2) == 0);
      drive(clr, conf, st, kn, 4'(n), rdy);
      model_step(clr, conf, st, kn, n, rdy);
      chk_all($sformatf("rnd%0d", i), 16'(m_entry), m_mode == 1, m_lv, 16'(m_lbcd), m_start, m_err);
    end
    idle_inputs();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
